// File: rtl/mem_bus_arbiter.sv
// Round-robin arbiter granting the external memory bus to the Icache or Dcache
// for fixed-length bursts, with a one-cycle idle turnaround between bursts.
module mem_bus_arbiter #(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned BURST_LEN  = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  Icache_Req,
  input  logic [ADDR_WIDTH-1:0] Icache_Addr,
  output logic                  Icache_Gnt,
  output logic                  Icache_RValid,
  output logic                  Icache_Done,
  input  logic                  Dcache_Req,
  input  logic                  Dcache_We,
  input  logic [ADDR_WIDTH-1:0] Dcache_Addr,
  input  logic [DATA_WIDTH-1:0] Dcache_WData,
  output logic                  Dcache_Gnt,
  output logic                  Dcache_WReady,
  output logic                  Dcache_RValid,
  output logic                  Dcache_Done,
  output logic [DATA_WIDTH-1:0] Mem_RData,
  input  logic                  Fence_Hold,
  output logic                  Arb_Busy,
  output logic                  Bus_Req,
  output logic                  Bus_We,
  output logic [ADDR_WIDTH-1:0] Bus_Addr,
  output logic [DATA_WIDTH-1:0] Bus_WData,
  input  logic                  Bus_Ack,
  input  logic [DATA_WIDTH-1:0] Bus_RData
);

  localparam int unsigned BEAT_W     = $clog2(BURST_LEN);
  localparam int unsigned BEAT_BYTES = DATA_WIDTH / 8;

  typedef enum logic {IDLE, BURST} state_t;

  // owner / lastOwner encoding: 1 = Dcache, 0 = Icache
  state_t                stateQ, stateD;
  logic                  ownerQ, ownerD;
  logic                  lastOwnerQ, lastOwnerD;
  logic                  weQ, weD;
  logic [ADDR_WIDTH-1:0] baseQ, baseD;
  logic [BEAT_W-1:0]     beatQ, beatD;

  logic dcEligible, icEligible, lastBeat;

  assign dcEligible = Dcache_Req;
  assign icEligible = Icache_Req & ~Fence_Hold;
  assign lastBeat   = (beatQ == BEAT_W'(BURST_LEN - 1));

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      stateQ     <= IDLE;
      ownerQ     <= 1'b0;
      lastOwnerQ <= 1'b0;
      weQ        <= 1'b0;
      baseQ      <= '0;
      beatQ      <= '0;
    end else begin
      stateQ     <= stateD;
      ownerQ     <= ownerD;
      lastOwnerQ <= lastOwnerD;
      weQ        <= weD;
      baseQ      <= baseD;
      beatQ      <= beatD;
    end
  end

  // Next-state: grant in IDLE, count acknowledged beats in BURST
  always_comb begin
    stateD     = stateQ;
    ownerD     = ownerQ;
    lastOwnerD = lastOwnerQ;
    weD        = weQ;
    baseD      = baseQ;
    beatD      = beatQ;
    unique case (stateQ)
      IDLE: begin
        if (dcEligible || icEligible) begin
          // On a tie the cache that did not own the previous burst wins
          ownerD     = (dcEligible && icEligible) ? ~lastOwnerQ : dcEligible;
          lastOwnerD = ownerD;
          weD        = ownerD & Dcache_We;
          baseD      = ownerD ? Dcache_Addr : Icache_Addr;
          beatD      = '0;
          stateD     = BURST;
        end
      end
      BURST: begin
        if (Bus_Ack) begin
          beatD = beatQ + BEAT_W'(1);
          if (lastBeat) begin
            stateD = IDLE;
          end
        end
      end
      default: stateD = IDLE;
    endcase
  end

  // Outputs: grants/direction from registered state, beat responses from Bus_Ack
  always_comb begin
    Bus_Req       = 1'b0;
    Bus_We        = 1'b0;
    Bus_Addr      = '0;
    Bus_WData     = '0;
    Icache_Gnt    = 1'b0;
    Dcache_Gnt    = 1'b0;
    Icache_RValid = 1'b0;
    Dcache_RValid = 1'b0;
    Dcache_WReady = 1'b0;
    Icache_Done   = 1'b0;
    Dcache_Done   = 1'b0;
    Mem_RData     = '0;
    Arb_Busy      = (stateQ == BURST) | dcEligible | icEligible;
    if (stateQ == BURST) begin
      Bus_Req    = 1'b1;
      Bus_We     = weQ;
      Bus_Addr   = baseQ + ADDR_WIDTH'(beatQ) * ADDR_WIDTH'(BEAT_BYTES);
      Bus_WData  = Dcache_WData;
      Icache_Gnt = ~ownerQ;
      Dcache_Gnt = ownerQ;
      if (weQ) begin
        Dcache_WReady = Bus_Ack;
      end else begin
        Icache_RValid = ~ownerQ & Bus_Ack;
        Dcache_RValid = ownerQ & Bus_Ack;
        Mem_RData     = Bus_Ack ? Bus_RData : '0;
      end
      Icache_Done = ~ownerQ & Bus_Ack & lastBeat;
      Dcache_Done = ownerQ & Bus_Ack & lastBeat;
    end
  end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Randomized and directed bench for mem_bus_arbiter, checked every cycle against
// a transaction-level model of the arbitration and burst rules.
module tb_mem_bus_arbiter;

  localparam int unsigned AW = 32;
  localparam int unsigned DW = 32;
  localparam int unsigned BL = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          Icache_Req, Icache_Gnt, Icache_RValid, Icache_Done;
  logic [AW-1:0] Icache_Addr;
  logic          Dcache_Req, Dcache_We, Dcache_Gnt, Dcache_WReady, Dcache_RValid, Dcache_Done;
  logic [AW-1:0] Dcache_Addr;
  logic [DW-1:0] Dcache_WData, Mem_RData;
  logic          Fence_Hold, Arb_Busy, Bus_Req, Bus_We, Bus_Ack;
  logic [AW-1:0] Bus_Addr;
  logic [DW-1:0] Bus_WData, Bus_RData;

  mem_bus_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .BURST_LEN(BL)) dut (
    .clk(clk), .rst(rst),
    .Icache_Req(Icache_Req), .Icache_Addr(Icache_Addr), .Icache_Gnt(Icache_Gnt),
    .Icache_RValid(Icache_RValid), .Icache_Done(Icache_Done),
    .Dcache_Req(Dcache_Req), .Dcache_We(Dcache_We), .Dcache_Addr(Dcache_Addr),
    .Dcache_WData(Dcache_WData), .Dcache_Gnt(Dcache_Gnt), .Dcache_WReady(Dcache_WReady),
    .Dcache_RValid(Dcache_RValid), .Dcache_Done(Dcache_Done), .Mem_RData(Mem_RData),
    .Fence_Hold(Fence_Hold), .Arb_Busy(Arb_Busy), .Bus_Req(Bus_Req), .Bus_We(Bus_We),
    .Bus_Addr(Bus_Addr), .Bus_WData(Bus_WData), .Bus_Ack(Bus_Ack), .Bus_RData(Bus_RData)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Transaction model: is a burst running, who owns it, how many beats are done
  bit          mBusy = 1'b0;
  bit          mOwnerD = 1'b0;
  bit          mLastD = 1'b0;
  bit          mWe = 1'b0;
  logic [31:0] mBase = '0;
  int          mBeats = 0;
  bit          dWants, iWants;

  always @(posedge clk) begin
    dWants = Dcache_Req;
    iWants = Icache_Req && !Fence_Hold;
    if (rst) begin
      mBusy  = 1'b0;
      mLastD = 1'b0;
      mBeats = 0;
    end else if (mBusy) begin
      if (Bus_Ack) begin
        mBeats = mBeats + 1;
        if (mBeats == BL) mBusy = 1'b0;
      end
    end else if (dWants || iWants) begin
      if (dWants && iWants) mOwnerD = !mLastD;
      else                  mOwnerD = dWants;
      mLastD = mOwnerD;
      mBusy  = 1'b1;
      mWe    = mOwnerD && Dcache_We;
      mBase  = mOwnerD ? Dcache_Addr : Icache_Addr;
      mBeats = 0;
    end
  end

  // Per-cycle comparison of every output against the model
  bit          eI, eD, eFin, eRd;
  logic [31:0] eAddr;
  always @(negedge clk) begin
    eI    = mBusy && !mOwnerD;
    eD    = mBusy && mOwnerD;
    eFin  = mBusy && (mBeats == BL - 1) && Bus_Ack;
    eRd   = mBusy && !mWe && Bus_Ack;
    eAddr = mBusy ? mBase + 32'(mBeats * (DW / 8)) : 32'h0;
    chk("m_bus_req", 32'(Bus_Req), 32'(mBusy));
    chk("m_icache_gnt", 32'(Icache_Gnt), 32'(eI));
    chk("m_dcache_gnt", 32'(Dcache_Gnt), 32'(eD));
    chk("m_bus_we", 32'(Bus_We), 32'(mBusy && mWe));
    chk("m_bus_addr", Bus_Addr, eAddr);
    chk("m_bus_wdata", Bus_WData, mBusy ? Dcache_WData : 32'h0);
    chk("m_icache_rvalid", 32'(Icache_RValid), 32'(eI && Bus_Ack));
    chk("m_dcache_rvalid", 32'(Dcache_RValid), 32'(eD && !mWe && Bus_Ack));
    chk("m_dcache_wready", 32'(Dcache_WReady), 32'(eD && mWe && Bus_Ack));
    chk("m_icache_done", 32'(Icache_Done), 32'(eI && eFin));
    chk("m_dcache_done", 32'(Dcache_Done), 32'(eD && eFin));
    chk("m_mem_rdata", Mem_RData, eRd ? Bus_RData : 32'h0);
    chk("m_arb_busy", 32'(Arb_Busy), 32'(mBusy || Dcache_Req || (Icache_Req && !Fence_Hold)));
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic doReset();
    rst = 1'b1;
    cyc();
    cyc();
    rst = 1'b0;
  endtask

  bit          ackPat[7]   = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
  logic [31:0] t3Addr[7]   = '{32'h4000, 32'h4004, 32'h4004, 32'h4004, 32'h4008, 32'h400C, 32'h400C};
  logic [31:0] wrapAddr[4] = '{32'hFFFF_FFF8, 32'hFFFF_FFFC, 32'h0000_0000, 32'h0000_0004};
  bit          grantLog[$];
  bit          prevReq;
  int          wrCount, icDoneCount, idleCount, seenDone;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, checks %0d", checks);
    $fatal(1);
  end

  initial begin
    rst = 1'b1;
    Icache_Req = 0; Icache_Addr = '0; Dcache_Req = 0; Dcache_We = 0; Dcache_Addr = '0;
    Dcache_WData = '0; Fence_Hold = 0; Bus_Ack = 0; Bus_RData = '0;

    // Reset state
    @(negedge clk);
    chk("rst_bus_req", 32'(Bus_Req), 32'h0);
    chk("rst_gnts", 32'({Icache_Gnt, Dcache_Gnt}), 32'h0);
    chk("rst_arb_busy", 32'(Arb_Busy), 32'h0);
    chk("rst_bus_addr", Bus_Addr, 32'h0);
    cyc();

    // Single Dcache read burst, always acknowledged
    Dcache_Req = 1; Dcache_We = 0; Dcache_Addr = 32'h1000; Bus_Ack = 1; Bus_RData = 32'hCAFE_0000;
    rst = 1'b0;
    cyc();
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("t1_gnt", 32'(Dcache_Gnt), 32'h1);
      chk("t1_addr", Bus_Addr, 32'h1000 + 32'(4 * i));
      chk("t1_rvalid", 32'(Dcache_RValid), 32'h1);
      chk("t1_rdata", Mem_RData, 32'hCAFE_0000);
      chk("t1_done", 32'(Dcache_Done), 32'(i == 3));
      cyc();
      if (i == 2) Dcache_Req = 0;
    end
    @(negedge clk);
    chk("t1_turnaround", 32'(Bus_Req), 32'h0);

    // Both caches requesting continuously: grants must alternate starting with Dcache
    doReset();
    Icache_Req = 1; Icache_Addr = 32'h2000;
    Dcache_Req = 1; Dcache_We = 1; Dcache_Addr = 32'h3000; Dcache_WData = 32'h1234_5678;
    cyc();
    prevReq = 0; wrCount = 0; icDoneCount = 0; idleCount = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (Bus_Req && !prevReq) grantLog.push_back(Dcache_Gnt);
      prevReq = Bus_Req;
      wrCount += int'(Dcache_WReady);
      icDoneCount += int'(Icache_Done);
      idleCount += int'(!Bus_Req);
      cyc();
      if (k == 18) begin Icache_Req = 0; Dcache_Req = 0; end
    end
    chk("t2_grant_count", 32'(grantLog.size()), 32'd4);
    while (grantLog.size() < 4) grantLog.push_back(1'b0);
    chk("t2_order", 32'({grantLog[0], grantLog[1], grantLog[2], grantLog[3]}), 32'b1010);
    chk("t2_wready_pulses", 32'(wrCount), 32'd8);
    chk("t2_icache_dones", 32'(icDoneCount), 32'd2);
    chk("t2_idle_cycles", 32'(idleCount), 32'd4);

    // Icache burst with wait states
    Icache_Req = 1; Icache_Addr = 32'h4000; Bus_Ack = 0;
    cyc();
    for (int k = 0; k < 7; k++) begin
      Bus_Ack = ackPat[k];
      Bus_RData = 32'hBEEF_0000 + 32'(k);
      @(negedge clk);
      chk("t3_gnt", 32'(Icache_Gnt), 32'h1);
      chk("t3_addr", Bus_Addr, t3Addr[k]);
      chk("t3_rvalid", 32'(Icache_RValid), 32'(ackPat[k]));
      chk("t3_done", 32'(Icache_Done), 32'(k == 6));
      chk("t3_dcache_quiet", 32'({Dcache_Gnt, Dcache_RValid, Dcache_WReady, Dcache_Done}), 32'h0);
      cyc();
      if (k == 5) Icache_Req = 0;
    end
    Bus_Ack = 1;

    // Fence blocks Icache, not Dcache; does not abort a running Icache burst
    Fence_Hold = 1; Icache_Req = 1; Icache_Addr = 32'h6000;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("t4_fenced_req", 32'(Bus_Req), 32'h0);
      chk("t4_fenced_busy", 32'(Arb_Busy), 32'h0);
      cyc();
    end
    Dcache_Req = 1; Dcache_We = 0; Dcache_Addr = 32'h7000;
    cyc();
    @(negedge clk);
    chk("t4_dcache_under_fence", 32'({Icache_Gnt, Dcache_Gnt}), 32'b01);
    cyc();
    Dcache_Req = 0;
    repeat (5) cyc();
    Fence_Hold = 0;
    cyc();
    cyc();
    Fence_Hold = 1; Icache_Req = 0;
    seenDone = 0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      seenDone += int'(Icache_Done);
      cyc();
    end
    chk("t4_fence_mid_burst_done", 32'(seenDone), 32'd1);
    Fence_Hold = 0;

    // Reset in the middle of a Dcache write burst
    Dcache_Req = 1; Dcache_We = 1; Dcache_Addr = 32'h5000; Bus_Ack = 1;
    cyc();
    cyc();
    cyc();
    rst = 1; Icache_Req = 1; Icache_Addr = 32'h8000;
    @(negedge clk);
    chk("t5_beat2_wready", 32'(Dcache_WReady), 32'h1);
    chk("t5_beat2_no_done", 32'(Dcache_Done), 32'h0);
    cyc();
    rst = 0;
    @(negedge clk);
    chk("t5_after_rst_req", 32'(Bus_Req), 32'h0);
    chk("t5_after_rst_gnt", 32'({Icache_Gnt, Dcache_Gnt}), 32'h0);
    chk("t5_after_rst_done", 32'({Icache_Done, Dcache_Done}), 32'h0);
    cyc();
    @(negedge clk);
    chk("t5_dcache_first", 32'({Icache_Gnt, Dcache_Gnt}), 32'b01);
    chk("t5_addr", Bus_Addr, 32'h5000);
    cyc();
    Dcache_Req = 0; Icache_Req = 0;
    repeat (6) cyc();

    // Address wrap-around
    Dcache_Req = 1; Dcache_We = 0; Dcache_Addr = 32'hFFFF_FFF8;
    cyc();
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("t6_wrap_addr", Bus_Addr, wrapAddr[i]);
      cyc();
      if (i == 0) Dcache_Req = 0;
    end
    cyc();

    // Random traffic against the model
    for (int n = 0; n < 600; n++) begin
      rst          = ($urandom_range(0, 79) == 0);
      Icache_Req   = ($urandom_range(0, 3) != 0);
      Dcache_Req   = ($urandom_range(0, 2) != 0);
      Dcache_We    = $urandom_range(0, 1) == 1;
      Icache_Addr  = $urandom & ~32'hF;
      Dcache_Addr  = $urandom & ~32'hF;
      Dcache_WData = $urandom;
      Bus_RData    = $urandom;
      Fence_Hold   = ($urandom_range(0, 4) == 0);
      Bus_Ack      = ($urandom_range(0, 3) != 0);
      cyc();
    end
    rst = 0; Icache_Req = 0; Dcache_Req = 0; Fence_Hold = 0; Bus_Ack = 1;
    repeat (8) cyc();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_bus_arbiter.md
Name: mem_bus_arbiter

Overview:
- Arbitrates the single external memory bus between the Icache refill port (read-only) and the Dcache refill/writeback port (read or write).
- Sequences fixed-length bursts and uses round-robin between the two caches when both request.
- Reports bus occupancy to the pipeline controller so a fence can drain outstanding memory traffic.
- Sits between the two caches and the bus interface unit.

Parameters:
ADDR_WIDTH, 32, address width of all address ports
DATA_WIDTH, 32, beat data width
BURST_LEN, 4, beats per transaction (power of two, 2..16)

Ports:
clk  input  1  clock
rst  input  1  synchronous active-high reset
Icache_Req  input  1  Icache burst read request, held until Icache_Done
Icache_Addr  input  ADDR_WIDTH  Icache burst base address, line-aligned
Icache_Gnt  output  1  Icache owns the bus
Icache_RValid  output  1  read beat valid for Icache
Icache_Done  output  1  final beat of Icache burst
Dcache_Req  input  1  Dcache burst request, held until Dcache_Done
Dcache_We  input  1  1 = write burst, 0 = read burst
Dcache_Addr  input  ADDR_WIDTH  Dcache burst base address, line-aligned
Dcache_WData  input  DATA_WIDTH  current write beat
Dcache_Gnt  output  1  Dcache owns the bus
Dcache_WReady  output  1  write beat accepted; Dcache advances to next beat
Dcache_RValid  output  1  read beat valid for Dcache
Dcache_Done  output  1  final beat of Dcache burst
Mem_RData  output  DATA_WIDTH  read beat data, shared by both caches
Fence_Hold  input  1  from Ctrl; blocks new Icache grants
Arb_Busy  output  1  burst in progress or request pending
Bus_Req  output  1  bus transaction active
Bus_We  output  1  write direction
Bus_Addr  output  ADDR_WIDTH  current beat address
Bus_WData  output  DATA_WIDTH  write beat data
Bus_Ack  input  1  beat completes this cycle
Bus_RData  input  DATA_WIDTH  read beat data, valid with Bus_Ack

Behaviour:
- Reset: all registered state cleared.
  - State = IDLE, owner = none, last_owner = Icache (so Dcache wins the first tie), beat counter = 0.
  - All outputs 0.
  - Reset mid-burst aborts the burst: Bus_Req is 0 the cycle after the reset edge. No Done pulse is issued.
- States:
  - IDLE: Bus_Req = 0, no Gnt asserted.
  - BURST: Bus_Req = 1, exactly one Gnt asserted.
- IDLE -> BURST on a clock edge when an eligible request exists.
  - Eligible requests: Dcache_Req, and Icache_Req && !Fence_Hold.
  - One eligible request: grant it.
  - Both eligible: grant the one that is not last_owner.
  - At the grant edge, register owner, We (Dcache_We for Dcache, 0 for Icache), base address, and beat = 0. Set last_owner = owner.
- BURST:
  - Bus_Addr = base + beat*(DATA_WIDTH/8), in ADDR_WIDTH-bit arithmetic. Wrap-around modulo 2^ADDR_WIDTH is allowed.
  - Bus_We = registered We.
  - Bus_WData = Dcache_WData, combinational passthrough, regardless of owner.
  - Each cycle with Bus_Ack = 1 completes one beat and beat increments.
  - Cycles with Bus_Ack = 0 are wait states; all outputs hold.
- Beat responses are combinational from Bus_Ack in the same cycle:
  - Read: owner RValid = Bus_Ack, Mem_RData = Bus_RData.
  - Write: Dcache_WReady = Bus_Ack.
  - The non-owner's RValid, WReady and Done stay 0.
- Final beat (beat == BURST_LEN-1 and Bus_Ack):
  - Owner Done = 1 for that cycle.
  - Next state is IDLE, which enforces a mandatory one-cycle Bus_Req = 0 turnaround between bursts.
  - Minimum burst occupancy is BURST_LEN cycles, plus one IDLE cycle.
- Gnt is level: high for the whole BURST state of the owner. Gnt is registered.
- Requests sampled only in IDLE:
  - A request dropped during BURST does not abort the burst; it completes.
  - Addr/We changes during BURST are ignored.
- Fence_Hold:
  - Does not abort an Icache burst already in progress.
  - While high, a waiting Icache request is not granted and does not count for round-robin.
- Arb_Busy = (state == BURST) | Dcache_Req | (Icache_Req & !Fence_Hold). Ctrl stalls fence retirement on it.
- Simultaneous events:
  - Done of one cache and a new request from the same cache in the same cycle: the new request is considered in the following IDLE cycle under round-robin.
  - The other cache, if waiting, wins because it is not last_owner.
- Starvation-free: with both requesters continuously active and no fence, grants strictly alternate.

Test Plan:
- Reset, Dcache_Req = 1, We = 0, Addr = 0x1000, Bus_Ack = 1 always -> Dcache_Gnt from cycle 1 for 4 cycles; Bus_Addr 0x1000/04/08/0C; Dcache_RValid on each beat; Dcache_Done on beat 3; Bus_Req = 0 in cycle 5.
- Both request continuously (Icache 0x2000, Dcache 0x3000 write) -> order Dcache, Icache, Dcache, Icache. One idle cycle between bursts. Dcache_WReady pulses 4 per write burst.
- Icache burst with Bus_Ack pattern 1,0,0,1,1,0,1 -> Bus_Addr held during 0 cycles; Icache_Done only on the 4th ack; no Dcache outputs asserted.
- Fence_Hold = 1 with Icache_Req only -> no grant, Arb_Busy = 0. Fence_Hold rises mid Icache burst -> burst completes with Done. Dcache_Req under Fence_Hold -> granted normally.
- rst asserted at beat 2 of a Dcache write -> next cycle Bus_Req = 0, Gnt = 0, no Done. After release with Icache_Req and Dcache_Req both high -> Dcache granted first.
- Addr = 0xFFFFFFF8, BURST_LEN = 4 -> Bus_Addr FFFFFFF8, FFFFFFFC, 00000000, 00000004.
